// File: rtl/bus_master_ctrl_pkg.sv
// bus_master_ctrl_pkg
//   Shared definitions for the client-side bus master controller: bus word
//   widths, read/write encoding and the controller FSM state encoding.
//   Optional feature macro used by the controller: BUS_TIMEOUT_EN.
package bus_master_ctrl_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;

  // Bus read/write encoding.
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [1:0] {
    BUS_MST_IDLE   = 2'd0,
    BUS_MST_REQ    = 2'd1,
    BUS_MST_ACCESS = 2'd2,
    BUS_MST_WAIT   = 2'd3
  } bus_mst_state_e;

endpackage

// File: rtl/bus_master_ctrl_if.sv
// bus_master_ctrl_if
//   Groups the client request/acknowledge signals and one master port of the
//   system bus.
//   master modport (controller side):
//     in : c_req, c_addr, c_rw, c_wr_data, grnt_n, rd_data, rdy_n
//     out: c_rd_data, c_ack, c_err, c_busy, req_n, addr, as_n, rw, wr_data
//   slave modport: the same signals with directions reversed.
//   Handshake: the client holds c_req high (level) until the controller has
//   accepted it in IDLE; completion is a single-cycle c_ack with c_err and
//   c_rd_data valid in that same cycle. On the bus, req_n stays low from
//   acceptance until completion, as_n is low for exactly one cycle after the
//   grant, and the transfer ends on the first rdy_n=0 sampled after as_n.
interface bus_master_ctrl_if;
  import bus_master_ctrl_pkg::*;

  logic                   c_req;
  logic [WORD_ADDR_W-1:0] c_addr;
  logic                   c_rw;
  logic [WORD_DATA_W-1:0] c_wr_data;
  logic [WORD_DATA_W-1:0] c_rd_data;
  logic                   c_ack;
  logic                   c_err;
  logic                   c_busy;

  logic                   req_n;
  logic                   grnt_n;
  logic [WORD_ADDR_W-1:0] addr;
  logic                   as_n;
  logic                   rw;
  logic [WORD_DATA_W-1:0] wr_data;
  logic [WORD_DATA_W-1:0] rd_data;
  logic                   rdy_n;

  modport master (
    input  c_req, c_addr, c_rw, c_wr_data, grnt_n, rd_data, rdy_n,
    output c_rd_data, c_ack, c_err, c_busy, req_n, addr, as_n, rw, wr_data
  );

  modport slave (
    output c_req, c_addr, c_rw, c_wr_data, grnt_n, rd_data, rdy_n,
    input  c_rd_data, c_ack, c_err, c_busy, req_n, addr, as_n, rw, wr_data
  );

endinterface

// File: rtl/bus_master_ctrl_timeout_cnt.sv
// bus_timeout_cnt
//   WAIT-state watchdog for bus_master_ctrl (only built with BUS_TIMEOUT_EN).
//   Ports:
//     clk, reset  : clock, asynchronous active-low reset
//     clr_i       : clear the count (entry to ACCESS)
//     en_i        : count one WAIT cycle
//     expired_o   : the current WAIT cycle is cycle number CYCLES
module bus_timeout_cnt #(
  parameter int CYCLES = 16,
  parameter int W      = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // cnt_q holds the number of WAIT cycles already completed, so the
  // CYCLES-th WAIT cycle sees CYCLES-1 and the abort lands on its edge.
  assign expired_o = (cnt_q == W'(CYCLES - 1));

endmodule

// File: rtl/bus_master_ctrl.sv
// bus_master_ctrl
//   Client-side bus master: turns a level client request into one bus
//   transfer (request, grant, one address strobe, wait for ready) and returns
//   a single-cycle acknowledge. All outputs are registered.
//   Ports:
//     clk     : system clock, rising edge
//     reset   : asynchronous, active-low reset
//     bus     : bus_master_ctrl_if.master (client + bus master port)
//     state_o : current FSM state (debug)
//   Optional feature macro: BUS_TIMEOUT_EN -- bounds WAIT to TIMEOUT_CYCLES
//   cycles and reports an abort through c_err. Without it WAIT is unbounded
//   and c_err is constant 0.
module bus_master_ctrl
  import bus_master_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  bus_master_ctrl_if.master bus,
  output bus_mst_state_e    state_o
);

  if (TIMEOUT_CYCLES < 1 || (1 << TIMEOUT_W) <= TIMEOUT_CYCLES) begin : g_bad_timeout_cfg
    $error("bus_master_ctrl: TIMEOUT_W too narrow for TIMEOUT_CYCLES");
  end

  bus_mst_state_e         state_q, state_d;
  logic                   req_n_q, req_n_d;
  logic                   as_n_q, as_n_d;
  logic                   rw_q, rw_d;
  logic                   c_ack_q, c_ack_d;
  logic                   c_busy_q, c_busy_d;
  logic [WORD_ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_DATA_W-1:0] wr_data_q, wr_data_d;
  logic [WORD_DATA_W-1:0] c_rd_data_q, c_rd_data_d;
  logic                   done;

`ifdef BUS_TIMEOUT_EN
  logic c_err_q, c_err_d;
  logic tmo_clr, tmo_en, tmo_expired;

  bus_timeout_cnt #(
    .CYCLES (TIMEOUT_CYCLES),
    .W      (TIMEOUT_W)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_expired)
  );
`endif

  always_comb begin
    state_d     = state_q;
    req_n_d     = req_n_q;
    as_n_d      = 1'b1;          // strobe is a one-cycle pulse
    addr_d      = addr_q;
    rw_d        = rw_q;
    wr_data_d   = wr_data_q;
    c_rd_data_d = c_rd_data_q;
    c_ack_d     = 1'b0;
    done        = 1'b0;
`ifdef BUS_TIMEOUT_EN
    c_err_d     = 1'b0;
    tmo_clr     = 1'b0;
    tmo_en      = 1'b0;
`endif

    case (state_q)
      BUS_MST_IDLE: begin
        if (bus.c_req) begin
          addr_d    = bus.c_addr;
          rw_d      = bus.c_rw;
          wr_data_d = bus.c_wr_data;
          req_n_d   = 1'b0;
          state_d   = BUS_MST_REQ;
        end
      end
      // rdy_n/rd_data here belong to another master's transfer.
      BUS_MST_REQ: begin
        if (!bus.grnt_n) begin
          as_n_d  = 1'b0;
          state_d = BUS_MST_ACCESS;
`ifdef BUS_TIMEOUT_EN
          tmo_clr = 1'b1;
`endif
        end
      end
      BUS_MST_ACCESS: begin
        if (!bus.rdy_n) done = 1'b1;
        else            state_d = BUS_MST_WAIT;
      end
      BUS_MST_WAIT: begin
        // A ready arriving on the expiry cycle still completes normally.
        if (!bus.rdy_n) begin
          done = 1'b1;
        end
`ifdef BUS_TIMEOUT_EN
        else if (tmo_expired) begin
          req_n_d = 1'b1;
          c_ack_d = 1'b1;
          c_err_d = 1'b1;
          state_d = BUS_MST_IDLE;
        end else begin
          tmo_en = 1'b1;
        end
`endif
      end
      default: state_d = BUS_MST_IDLE;
    endcase

    if (done) begin
      req_n_d = 1'b1;
      c_ack_d = 1'b1;
      if (rw_q == READ) c_rd_data_d = bus.rd_data;
      state_d = BUS_MST_IDLE;
    end

    c_busy_d = (state_d != BUS_MST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= BUS_MST_IDLE;
      req_n_q     <= 1'b1;
      as_n_q      <= 1'b1;
      rw_q        <= READ;
      addr_q      <= '0;
      wr_data_q   <= '0;
      c_rd_data_q <= '0;
      c_ack_q     <= 1'b0;
      c_busy_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_n_q     <= req_n_d;
      as_n_q      <= as_n_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      c_rd_data_q <= c_rd_data_d;
      c_ack_q     <= c_ack_d;
      c_busy_q    <= c_busy_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) c_err_q <= 1'b0;
    else        c_err_q <= c_err_d;
  end
  assign bus.c_err = c_err_q;
`else
  assign bus.c_err = 1'b0;
`endif

  assign bus.req_n     = req_n_q;
  assign bus.as_n      = as_n_q;
  assign bus.rw        = rw_q;
  assign bus.addr      = addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.c_rd_data = c_rd_data_q;
  assign bus.c_ack     = c_ack_q;
  assign bus.c_busy    = c_busy_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_bus_master_ctrl.sv
// tb_bus_master_ctrl
//   Bench for bus_master_ctrl. A driver plays client, arbiter and slave;
//   each issued request pushes its expected bus strobe and its expected
//   acknowledge into queues, and a monitor pops/compares them whenever the
//   DUT strobes as_n or pulses c_ack. With BUS_TIMEOUT_EN defined the
//   timeout scenarios are also run.
module tb_bus_master_ctrl;
  import bus_master_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_master_ctrl_if bif();
  bus_mst_state_e    dut_state;

  bus_master_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bif.master),
    .state_o (dut_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q[$];      // {c_err, c_rd_data} expected at each c_ack
  logic [62:0] exp_bus_q[$];  // {addr, rw, wr_data} expected at each as_n
  logic [31:0] model_rd = '0; // client-visible read data
  bit          prev_as_low = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      prev_as_low = 1'b0;
    end else begin
      if (!bif.as_n) begin
        chk("as_n_one_cycle", prev_as_low, 1'b0);
        chk("strobe_expected", exp_bus_q.size() != 0, 1'b1);
        if (exp_bus_q.size() != 0) begin
          logic [62:0] b;
          b = exp_bus_q.pop_front();
          chk("bus_addr", bif.addr, b[62:33]);
          chk("bus_rw", bif.rw, b[32]);
          chk("bus_wr_data", bif.wr_data, b[31:0]);
        end
      end
      prev_as_low = !bif.as_n;
      if (bif.c_ack) begin
        chk("req_n_high_at_ack", bif.req_n, 1'b1);
        chk("busy_low_at_ack", bif.c_busy, 1'b0);
        chk("ack_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("ack_err", bif.c_err, e[32]);
          chk("ack_rd_data", bif.c_rd_data, e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present a request and record what the bus and the client must see.
  task automatic start_req(input logic [29:0] a, input logic r, input logic [31:0] wd,
                           input logic [31:0] rdata, input bit err);
    bif.c_req     = 1'b1;
    bif.c_addr    = a;
    bif.c_rw      = r;
    bif.c_wr_data = wd;
    exp_bus_q.push_back({a, r, wd});
    if (!err && r == READ) model_rd = rdata;
    exp_q.push_back({err, model_rd});
  endtask

  task automatic wait_req_low();
    int n = 0;
    do begin @(negedge clk); n++; end while (bif.req_n !== 1'b0 && n < 50);
    chk("req_n_asserted", bif.req_n, 1'b0);
  endtask

  task automatic wait_as_low();
    int n = 0;
    do begin @(negedge clk); n++; end while (bif.as_n !== 1'b0 && n < 50);
    chk("as_n_asserted", bif.as_n, 1'b0);
  endtask

  // Arbiter + slave side of one transfer. ws = rdy_n high cycles after as_n.
  task automatic run_txn(input bit hold, input int gdelay, input int ws, input logic [31:0] rdata);
    wait_req_low();
    if (!hold) bif.c_req = 1'b0;
    for (int g = 0; g < gdelay; g++) begin
      bif.grnt_n  = 1'b1;
      bif.rdy_n   = 1'($urandom_range(0, 1));
      bif.rd_data = $urandom;
      @(negedge clk);
      chk("as_n_before_grant", bif.as_n, 1'b1);
      chk("no_ack_before_grant", bif.c_ack, 1'b0);
    end
    bif.grnt_n  = 1'b0;
    bif.rdy_n   = 1'($urandom_range(0, 1));
    bif.rd_data = $urandom;
    wait_as_low();
    for (int w = 0; w < ws; w++) begin
      bif.rdy_n   = 1'b1;
      bif.rd_data = $urandom;
      bif.grnt_n  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("no_ack_while_waiting", bif.c_ack, 1'b0);
    end
    bif.rdy_n   = 1'b0;
    bif.rd_data = rdata;
    @(negedge clk);
    chk("ack_on_ready", bif.c_ack, 1'b1);
    bif.rdy_n   = 1'b1;
    bif.grnt_n  = 1'b1;
    bif.rd_data = $urandom;
  endtask

  // Idle with stray traffic from other masters on the shared bus.
  task automatic idle_cycles(input int n);
    bif.c_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      bif.rdy_n   = 1'($urandom_range(0, 1));
      bif.grnt_n  = 1'($urandom_range(0, 1));
      bif.rd_data = $urandom;
      @(negedge clk);
      chk("idle_req_n", bif.req_n, 1'b1);
      chk("idle_busy", bif.c_busy, 1'b0);
    end
    bif.rdy_n  = 1'b1;
    bif.grnt_n = 1'b1;
  endtask

`ifdef BUS_TIMEOUT_EN
  // WAIT entered at the edge after the as_n-low sample; abort or ready on the
  // edge that closes the 16th WAIT cycle.
  task automatic tmo_txn(input bit ready_at_expiry, input logic [31:0] rdata);
    start_req(30'($urandom), READ, 32'h0, rdata, !ready_at_expiry);
    wait_req_low();
    bif.c_req  = 1'b0;
    bif.grnt_n = 1'b0;
    wait_as_low();
    bif.rdy_n  = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("tmo_no_early_ack", bif.c_ack, 1'b0);
    end
    if (ready_at_expiry) begin
      bif.rdy_n   = 1'b0;
      bif.rd_data = rdata;
    end
    @(negedge clk);
    chk("tmo_ack_at_expiry", bif.c_ack, 1'b1);
    bif.rdy_n  = 1'b1;
    bif.grnt_n = 1'b1;
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    reset         = 1'b0;
    bif.c_req     = 1'b0;
    bif.c_addr    = '0;
    bif.c_rw      = READ;
    bif.c_wr_data = '0;
    bif.grnt_n    = 1'b1;
    bif.rdy_n     = 1'b1;
    bif.rd_data   = '0;
    repeat (3) @(negedge clk);

    chk("rst_req_n", bif.req_n, 1'b1);
    chk("rst_as_n", bif.as_n, 1'b1);
    chk("rst_rw", bif.rw, READ);
    chk("rst_addr", bif.addr, 30'h0);
    chk("rst_wr_data", bif.wr_data, 32'h0);
    chk("rst_c_rd_data", bif.c_rd_data, 32'h0);
    chk("rst_c_ack", bif.c_ack, 1'b0);
    chk("rst_c_err", bif.c_err, 1'b0);
    chk("rst_c_busy", bif.c_busy, 1'b0);
    reset = 1'b1;
    idle_cycles(2);

    // Write, immediate grant, zero-wait slave.
    start_req(30'h1000_0000, WRITE, 32'h1234, 32'h0, 1'b0);
    run_txn(1'b0, 0, 0, 32'hFFFF_FFFF);
    idle_cycles(3);

    // Read with three wait states.
    start_req(30'h3F00_0000, READ, 32'h0, 32'h5678, 1'b0);
    run_txn(1'b0, 1, 3, 32'h5678);
    idle_cycles(2);

    // Long grant delay with competing traffic.
    start_req(30'h0000_0042, READ, 32'h0, 32'hCAFE_0001, 1'b0);
    run_txn(1'b0, 5, 1, 32'hCAFE_0001);
    idle_cycles(1);

    // Back-to-back writes with c_req held high.
    for (int i = 0; i < 3; i++) begin
      start_req(30'h0200_0000 + 30'(i), WRITE, 32'hA000_0000 + 32'(i), 32'h0, 1'b0);
      run_txn(i < 2, 0, i, 32'h0);
    end
    idle_cycles(2);

    // Reset while in WAIT.
    start_req(30'h0ABC_DEF0, WRITE, 32'hDEAD_BEEF, 32'h0, 1'b0);
    wait_req_low();
    bif.c_req  = 1'b0;
    bif.grnt_n = 1'b0;
    wait_as_low();
    bif.rdy_n  = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_in_wait", bif.c_busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("async_rst_req_n", bif.req_n, 1'b1);
    chk("async_rst_as_n", bif.as_n, 1'b1);
    chk("async_rst_busy", bif.c_busy, 1'b0);
    chk("async_rst_ack", bif.c_ack, 1'b0);
    exp_q.delete();
    model_rd   = '0;
    bif.grnt_n = 1'b1;
    bif.rdy_n  = 1'b0;   // ready during reset must not produce an ack
    repeat (2) @(negedge clk);
    chk("rst_hold_ack", bif.c_ack, 1'b0);
    chk("rst_hold_rd_data", bif.c_rd_data, 32'h0);
    bif.rdy_n = 1'b1;
    reset     = 1'b1;
    idle_cycles(2);
    start_req(30'h0111_2222, READ, 32'h0, 32'h9ABC_DEF0, 1'b0);
    run_txn(1'b0, 2, 2, 32'h9ABC_DEF0);
    idle_cycles(1);

    // Randomized traffic.
    for (int i = 0; i < 25; i++) begin
      logic [29:0] a;
      logic        r;
      logic [31:0] wd, rd;
      a  = 30'($urandom);
      r  = 1'($urandom_range(0, 1));
      wd = $urandom;
      rd = $urandom;
      start_req(a, r, wd, rd, 1'b0);
      run_txn(1'b0, $urandom_range(0, 5), $urandom_range(0, 4), rd);
      idle_cycles($urandom_range(1, 3));
    end

`ifdef BUS_TIMEOUT_EN
    tmo_txn(1'b0, 32'h1111_2222);
    idle_cycles(2);
    tmo_txn(1'b1, 32'h3333_4444);
    idle_cycles(2);
`endif

    idle_cycles(4);
    chk("ack_queue_drained", exp_q.size(), 0);
    chk("strobe_queue_drained", exp_bus_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_master_ctrl.md
Name: bus_master_ctrl

Overview:
- Client-side bus master interface for the shared 4-master/8-slave system bus.
- Converts a simple client request/acknowledge into the bus protocol:
  - request the bus (req_n) and wait for the arbiter grant (grnt_n);
  - issue one address strobe (as_n) with addr/rw/wr_data;
  - wait for the shared ready (rdy_n), then release the bus.
- Instantiated once per bus master (CPU fetch, CPU data, DMA), between the client and one master port of bus_top.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in WAIT before abort. Used only with BUS_TIMEOUT_EN.
- TIMEOUT_W, 5: timeout counter width. Must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- c_req  in  1  client request, level, sampled only in IDLE.
- c_addr  in  30  client word address (`WORD_ADDR_BUS).
- c_rw  in  1  `READ / `WRITE.
- c_wr_data  in  32  write data (`WORD_DATA_BUS).
- c_rd_data  out  32  read data, registered, held until the next read completes.
- c_ack  out  1  one-cycle completion pulse.
- c_err  out  1  valid with c_ack; 1 = timeout abort.
- c_busy  out  1  high in every state except IDLE.
- req_n  out  1  bus request to arbiter.
- grnt_n  in  1  bus grant from arbiter.
- addr  out  30  bus address.
- as_n  out  1  address strobe.
- rw  out  1  bus read/write.
- wr_data  out  32  bus write data.
- rd_data  in  32  shared m_rd_data.
- rdy_n  in  1  shared m_rdy_n.

Behaviour:
- All outputs are registered.
- Reset values: req_n=1, as_n=1, rw=`READ, addr=0, wr_data=0, c_rd_data=0, c_ack=0, c_err=0, c_busy=0; state=IDLE.
- Reset asserted mid-transaction returns to IDLE immediately. req_n and as_n deassert asynchronously; no c_ack is issued.
- FSM states: IDLE, REQ, ACCESS, WAIT.
- IDLE:
  - c_req=1 at an edge: latch c_addr/c_rw/c_wr_data into addr/rw/wr_data, drive req_n=0, go to REQ.
  - c_req=0: hold.
- REQ:
  - Hold req_n=0 until grnt_n=0 is sampled.
  - At that edge drive as_n=0 and go to ACCESS.
  - No limit on grant wait.
- ACCESS:
  - as_n is low for exactly one cycle; it returns to 1 at the next edge.
  - rdy_n=0 sampled in ACCESS (zero-wait slave) means complete.
  - Otherwise go to WAIT.
- WAIT: hold until rdy_n=0 sampled, then complete.
- Completion edge:
  - req_n=1 and c_ack=1 for one cycle; c_err=0.
  - If rw=`READ, c_rd_data<=rd_data; writes leave c_rd_data unchanged.
  - Go to IDLE.
- Minimum latency, zero-wait slave: grant sampled at edge N → as_n low after N → ack after N+1.
- Back-to-back: c_req held high after c_ack is accepted at the first IDLE edge. req_n is therefore high for at least one cycle between transactions, so the arbiter can rotate.
- rdy_n/rd_data are ignored in IDLE and REQ, because they belong to another master's transaction.
- grnt_n changes in ACCESS/WAIT are ignored; the arbiter does not revoke the grant while req_n is held.
- addr/rw/wr_data remain stable from latch until the next accepted request.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W counter clears on entry to ACCESS and increments each cycle in WAIT.
  - When it reaches TIMEOUT_CYCLES with rdy_n=1: complete with c_ack=1, c_err=1, c_rd_data unchanged, req_n=1, go to IDLE.
  - rdy_n=0 in the same cycle as expiry wins: normal completion, c_err=0.
- Undefined: WAIT is unbounded, c_err is tied to 0, and no counter logic is present.

Decomposition:
- Existing global_std_def: LOW/HIGH, ENABLE_/DISABLE_, RESET_ENABLE.
- Shared bus_def package: WORD_ADDR_BUS/WIDTH, WORD_DATA_BUS/WIDTH, READ/WRITE.
- New bus_master_ctrl header: 2-bit state encodings BUS_MST_IDLE=0, REQ=1, ACCESS=2, WAIT=3.
- One sub-module, bus_timeout_cnt (clear/enable/expired), instantiated only under BUS_TIMEOUT_EN.

Test Plan:
1. Write, immediate grant: c_req with addr 30'h1000_0000, `WRITE, data 32'h1234; grnt_n low next cycle; rdy_n low during ACCESS → as_n low exactly 1 cycle with those values, c_ack 1 cycle, c_err=0, req_n high after ack, c_rd_data stays 0.
2. Read with wait states: addr 30'h3F00_0000, `READ; rdy_n low 3 cycles after as_n, rd_data 32'h5678 → c_rd_data=32'h5678 on ack; stray rdy_n pulses in IDLE/REQ are ignored.
3. Grant delay plus competing traffic: grnt_n held high 5 cycles while rdy_n toggles → as_n stays high, no ack; after grant the transaction completes normally.
4. Back-to-back: c_req held high for 3 writes → 3 c_ack pulses, req_n high ≥1 cycle between each, addr updated per request.
5. Reset mid-WAIT: assert reset while in WAIT → req_n=1, as_n=1, c_busy=0 immediately, no c_ack; after release the next request works.
6. BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, rdy_n never low → c_ack with c_err=1 exactly 16 cycles after WAIT entry, c_rd_data unchanged; rdy_n low on the expiry cycle → c_err=0.
